fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch front end for each core. Holds the program counter and drives the word-aligned byte address into the combinational instruction memory (addr -> instruction, same cycle).
- Captures the returned instruction plus PC+4 into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect, and halts fetch once the PC runs past the loaded program image.

Parameters:
- PC_RESET, 32'd0, PC value loaded on reset.
- PC_LIMIT, 32'd124, last valid fetch byte address (32-word memory, last word at 124).

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-low
- stall_i  in  1  hazard unit hold: PC and IF/ID keep their values
- flush_i  in  1  squash the IF/ID contents (branch resolved in a later stage)
- redirect_i  in  1  load a new PC (taken branch or jump)
- redirect_pc_i  in  32  redirect target byte address
- instr_i  in  32  instruction from memory for the current addr_o
- addr_o  out  32  current PC, sent to the instruction memory
- ifid_instr_o  out  32  IF/ID instruction
- ifid_pc4_o  out  32  IF/ID PC+4
- ifid_valid_o  out  1  IF/ID holds a real instruction
- halted_o  out  1  fetch halted; high in the HALT state

Behaviour:
- Reset (rst_i low, async):
  - pc=PC_RESET, ifid_instr_o=0, ifid_pc4_o=0, ifid_valid_o=0, halted_o=0, state=BOOT.
  - Reset asserted mid-operation discards everything immediately.
- addr_o is driven directly from the pc register. instr_i is sampled on the same rising edge, so fetch latency is one cycle from PC to IF/ID.
- Redirect alignment: redirect_pc_i[1:0] is forced to 2'b00 before it is loaded.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- State BOOT: exactly one cycle. No capture, pc holds, then go to RUN. Inputs are ignored in BOOT, except a redirect, which loads pc and still goes to RUN.
- State RUN, priority order per edge:
  1. redirect_i: pc<=target; IF/ID cleared (instr=0, pc4=0, valid=0). Overrides stall_i and flush_i. If target>PC_LIMIT, go to HALT.
  2. pc>PC_LIMIT: go to HALT, ifid_valid<=0, pc holds.
  3. flush_i: IF/ID cleared. If stall_i is also high, pc holds; otherwise pc<=pc+4 and the squashed instruction is not captured.
  4. stall_i: pc and IF/ID unchanged.
  5. Otherwise: ifid_instr<=instr_i, ifid_pc4<=pc+4, ifid_valid<=1, pc<=pc+4.
- State HALT:
  - halted_o=1, ifid_valid_o=0, pc holds, stall_i and flush_i are ignored.
  - redirect_i with an in-range target: pc<=target, go to RUN, halted_o falls the same edge.
  - redirect_i with an out-of-range target: pc<=target, stay in HALT.
- Encoding: a zero instruction word is a valid NOP and is captured with valid=1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt_o[31:0] and stall_cnt_o[31:0].
  - fetch_cnt_o increments on every IF/ID capture with valid=1.
  - stall_cnt_o increments on every RUN cycle where the stall hold is applied (priority 4).
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent and there is no other behavioural change.

Test Plan:
- Reset release, memory holds words W0..W3, no stalls -> addr_o is 0 during BOOT, then 0,4,8,12. ifid_instr_o=W0 and ifid_pc4_o=4, valid=1, on the edge after the first RUN cycle.
- stall_i held for 3 cycles at pc=8 -> addr_o stays 8, IF/ID unchanged for 3 cycles, then resumes with W2 (under the macro, stall_cnt_o=3).
- redirect_i with target 32'h0000002E and stall_i=1 in the same cycle -> pc=32'h2C next cycle, ifid_valid_o=0, next capture is word 11 with pc4=32'h30.
- flush_i together with stall_i at pc=16 -> ifid_valid_o=0, pc stays 16. flush_i alone at pc=16 -> valid=0, pc=20.
- Run sequentially to pc=128 -> halted_o=1 and ifid_valid_o=0 on that edge, pc holds 128. Redirect to 200 -> stays halted, pc=200. Redirect to 0 -> RUN, halted_o=0.
- Assert rst_i low asynchronously mid-stream at pc=40 with valid=1 -> all outputs return to reset values before the next clock edge; BOOT is repeated after release.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch and IF/ID register with stall/flush/redirect and halt past the image.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt_o/stall_cnt_o performance counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [31:0] PC_LIMIT = 32'd124
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] addr_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc4_o,
  output logic        ifid_valid_o,
  output logic        halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, instr_nx, pc4_nx, target, pc_inc;
  logic valid_nx, capture, hold;
  assign target = {redirect_pc_i[31:2], 2'b00};
  assign pc_inc = pc + 32'd4;
  assign addr_o = pc;
  assign halted_o = state == HALT;
  always_comb begin
    state_nx = state;
    pc_nx = pc;
    instr_nx = ifid_instr_o;
    pc4_nx = ifid_pc4_o;
    valid_nx = ifid_valid_o;
    capture = 1'b0;
    hold = 1'b0;
    case (state)
      BOOT: begin
        state_nx = RUN;
        pc_nx = redirect_i ? target : pc;
      end
      RUN: begin
        if (redirect_i) begin
          pc_nx = target;
          instr_nx = '0;
          pc4_nx = '0;
          valid_nx = 1'b0;
          state_nx = target > PC_LIMIT ? HALT : RUN;
        end else if (pc > PC_LIMIT) begin
          state_nx = HALT;
          valid_nx = 1'b0;
        end else if (flush_i) begin
          instr_nx = '0;
          pc4_nx = '0;
          valid_nx = 1'b0;
          pc_nx = stall_i ? pc : pc_inc;
        end else if (stall_i) begin
          hold = 1'b1;
        end else begin
          capture = 1'b1;
          instr_nx = instr_i;
          pc4_nx = pc_inc;
          valid_nx = 1'b1;
          pc_nx = pc_inc;
        end
      end
      HALT: begin
        valid_nx = 1'b0;
        if (redirect_i) begin
          pc_nx = target;
          state_nx = target > PC_LIMIT ? HALT : RUN;
        end
      end
      default: state_nx = BOOT;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= BOOT;
      pc <= PC_RESET;
      ifid_instr_o <= '0;
      ifid_pc4_o <= '0;
      ifid_valid_o <= 1'b0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      ifid_instr_o <= instr_nx;
      ifid_pc4_o <= pc4_nx;
      ifid_valid_o <= valid_nx;
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (capture && fetch_cnt_o != '1) fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (hold && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = capture ^ hold;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized and directed checking of fetch_stage against a cycle-level reference model.
module tb_fetch_stage;
  localparam logic [31:0] LIMIT = 32'd124;
  logic clk_i = 1'b0, rst_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, instr_i, addr_o, ifid_instr_o, ifid_pc4_o;
  logic ifid_valid_o, halted_o;
  logic [31:0] mem [32];
  int n_chk = 0, n_fail = 0;
  int m_mode;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic m_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o, m_fetch, m_stall;
`endif
  fetch_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .instr_i(instr_i),
    .addr_o(addr_o), .ifid_instr_o(ifid_instr_o), .ifid_pc4_o(ifid_pc4_o),
    .ifid_valid_o(ifid_valid_o), .halted_o(halted_o)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );
  always #5 clk_i = ~clk_i;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a <= LIMIT ? mem[a[6:2]] : ~a;
  endfunction
  assign instr_i = mem_word(addr_o);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_mode = 0;
    m_pc = 32'd0;
    m_instr = '0;
    m_pc4 = '0;
    m_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    m_fetch = '0;
    m_stall = '0;
`endif
  endtask
  task automatic check_all();
    check("addr", addr_o, m_pc);
    check("instr", ifid_instr_o, m_instr);
    check("pc4", ifid_pc4_o, m_pc4);
    check("valid", {31'd0, ifid_valid_o}, {31'd0, m_valid});
    check("halted", {31'd0, halted_o}, {31'd0, m_mode == 2});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt_o, m_fetch);
    check("stall_cnt", stall_cnt_o, m_stall);
`endif
  endtask
  // Model: mode 0 = boot, 1 = run, 2 = halted; one call per rising edge.
  task automatic model_step(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    logic [31:0] t;
    t = tg & ~32'd3;
    if (m_mode == 0) begin
      m_mode = 1;
      if (rd) m_pc = t;
    end else if (m_mode == 2) begin
      m_valid = 1'b0;
      if (rd) begin
        m_pc = t;
        m_mode = t > LIMIT ? 2 : 1;
      end
    end else if (rd) begin
      m_pc = t;
      {m_instr, m_pc4, m_valid} = '0;
      if (t > LIMIT) m_mode = 2;
    end else if (m_pc > LIMIT) begin
      m_mode = 2;
      m_valid = 1'b0;
    end else if (fl) begin
      {m_instr, m_pc4, m_valid} = '0;
      if (!st) m_pc = m_pc + 4;
    end else if (st) begin
`ifdef FETCH_PERF_CNT_EN
      if (m_stall != '1) m_stall = m_stall + 1;
`endif
    end else begin
      m_instr = mem_word(m_pc);
      m_pc4 = m_pc + 4;
      m_valid = 1'b1;
      m_pc = m_pc + 4;
`ifdef FETCH_PERF_CNT_EN
      if (m_fetch != '1) m_fetch = m_fetch + 1;
`endif
    end
  endtask
  task automatic cycle(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    stall_i = st;
    flush_i = fl;
    redirect_i = rd;
    redirect_pc_i = tg;
    @(posedge clk_i);
    model_step(st, fl, rd, tg);
    @(negedge clk_i);
    check_all();
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = (i == 5) ? 32'd0 : $urandom;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_all();
    rst_i = 1'b1;
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 32'h2E);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h10);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h10);
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 32'h0);
    for (int i = 0; i < 40 && m_mode != 2; i++) cycle(0, 0, 0, 0);
    check("halt_reached", {31'd0, halted_o}, 32'd1);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 32'd200);
    cycle(0, 0, 1, 32'd0);
    while (m_pc != 32'd40) cycle(0, 0, 0, 0);
    #2 rst_i = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk_i);
    check_all();
    rst_i = 1'b1;
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic rd;
      logic [31:0] tg;
      rd = $urandom_range(0, 15) == 0;
      tg = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 140);
      if (m_mode == 2 && $urandom_range(0, 3) == 0) rd = 1'b1;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, rd, tg);
      if (i == 1500) begin
        #2 rst_i = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk_i);
        rst_i = 1'b1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
